// File: rtl/seq_div_32_if.sv
// seq_div_32_if: request/result handshake bundle for the 32-bit sequential divider.
// master drives requests and consumes results; slave is the divider itself.
interface seq_div_32_if;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        OF;

  modport master (
    output start_valid, dividend, divisor, is_signed, out_ready,
    input  start_ready, out_valid, quotient, remainder, div_by_zero, OF
  );

  modport slave (
    input  start_valid, dividend, divisor, is_signed, out_ready,
    output start_ready, out_valid, quotient, remainder, div_by_zero, OF
  );
endinterface

// File: rtl/seq_div_32.sv
// seq_div_32: 32-bit restoring shift-subtract divider, one quotient bit per cycle.
// Result appears 32 cycles after accept; divide-by-zero short-circuits to DONE.
// Signed (two's-complement) support is compiled in only when SEQ_DIV_SIGNED_EN
// is defined; otherwise is_signed is ignored and OF is always 0.
module seq_div_32 (
  input  logic         clk,
  input  logic         rst_n,
  seq_div_32_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_reg;
  logic [4:0]  count_reg;
  logic        start_ready_reg;
  logic        out_valid_reg;
  logic [31:0] quotient_reg;
  logic [31:0] remainder_reg;
  logic        dz_reg;
  logic        of_reg;

  // Datapath: quo_reg starts as the dividend magnitude and has quotient bits
  // shifted in from the bottom while dividend bits leave from the top.
  logic [31:0] quo_reg;
  logic [31:0] rem_reg;
  logic [31:0] dvs_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic        of_pend_reg;

  logic        accept;
  logic        op_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        is_ovf;

  logic [32:0] rem_shift;
  logic [32:0] rem_sub;
  logic        q_bit;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] final_q;
  logic [31:0] final_r;

`ifdef SEQ_DIV_SIGNED_EN
  assign op_signed = bus.is_signed;
`else
  logic unused_is_signed;
  assign unused_is_signed = bus.is_signed;
  assign op_signed        = 1'b0;
`endif

  assign accept = start_ready_reg & bus.start_valid;

  // Operand conditioning: divide magnitudes, remember which results to negate.
  assign a_neg  = op_signed & bus.dividend[31];
  assign b_neg  = op_signed & bus.divisor[31];
  assign a_mag  = a_neg ? (~bus.dividend + 32'd1) : bus.dividend;
  assign b_mag  = b_neg ? (~bus.divisor + 32'd1) : bus.divisor;
  assign is_ovf = op_signed && (bus.dividend == 32'h8000_0000) &&
                  (bus.divisor == 32'hFFFF_FFFF);

  // One restoring step: the 33-bit shifted partial remainder is compared with the
  // divisor via the borrow of a 33-bit subtract (bit 32 set means it was smaller).
  assign rem_shift = {rem_reg, quo_reg[31]};
  assign rem_sub   = rem_shift - {1'b0, dvs_reg};
  assign q_bit     = ~rem_sub[32];
  assign rem_step  = q_bit ? rem_sub[31:0] : rem_shift[31:0];
  assign quo_step  = {quo_reg[30:0], q_bit};
  assign final_q   = neg_q_reg ? (~quo_step + 32'd1) : quo_step;
  assign final_r   = neg_r_reg ? (~rem_step + 32'd1) : rem_step;

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      count_reg       <= 5'd0;
      start_ready_reg <= 1'b1;
      out_valid_reg   <= 1'b0;
      quotient_reg    <= 32'd0;
      remainder_reg   <= 32'd0;
      dz_reg          <= 1'b0;
      of_reg          <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            start_ready_reg <= 1'b0;
            if (bus.divisor == 32'd0) begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
              quotient_reg  <= 32'hFFFF_FFFF;
              remainder_reg <= bus.dividend;
              dz_reg        <= 1'b1;
              of_reg        <= 1'b0;
            end else begin
              state_reg <= BUSY;
              count_reg <= 5'd0;
            end
          end
        end
        BUSY: begin
          count_reg <= count_reg + 5'd1;
          if (count_reg == 5'd31) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            quotient_reg  <= final_q;
            remainder_reg <= final_r;
            dz_reg        <= 1'b0;
            of_reg        <= of_pend_reg;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg       <= IDLE;
            out_valid_reg   <= 1'b0;
            start_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg       <= IDLE;
          out_valid_reg   <= 1'b0;
          start_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // Datapath: capture operands on accept, then one shift-subtract step per BUSY cycle.
  always_ff @(posedge clk) begin
    if (state_reg == IDLE && accept) begin
      quo_reg     <= a_mag;
      rem_reg     <= 32'd0;
      dvs_reg     <= b_mag;
      neg_q_reg   <= a_neg ^ b_neg;
      neg_r_reg   <= a_neg;
      of_pend_reg <= is_ovf;
    end else if (state_reg == BUSY) begin
      quo_reg <= quo_step;
      rem_reg <= rem_step;
    end
  end

  assign bus.start_ready = start_ready_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dz_reg;
  assign bus.OF          = of_reg;

endmodule

// File: tb/tb_seq_div_32.sv
// tb_seq_div_32: vector table, random operands against an arithmetic model,
// plus hand-written handshake-stall and mid-operation reset sequences.
module tb_seq_div_32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

`ifdef SEQ_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  seq_div_32_if bus ();

  seq_div_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        of;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the division rules.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz, output logic of);
    int sa;
    int sb;
    dz = 1'b0;
    of = 1'b0;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else if (SIGNED_EN && s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q  = 32'h8000_0000;
        r  = 32'd0;
        of = 1'b1;
      end else begin
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one request, scramble inputs after accept, wait for result, consume it.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic dz, output logic of, output int lat);
    int waitc = 0;
    @(negedge clk);
    bus.dividend    = a;
    bus.divisor     = b;
    bus.is_signed   = s;
    bus.start_valid = 1'b1;
    while (!bus.start_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.start_ready) chk("accept_timeout", 32'(bus.start_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    bus.dividend    = $urandom;
    bus.divisor     = $urandom;
    bus.is_signed   = ~s;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q  = bus.quotient;
    r  = bus.remainder;
    dz = bus.div_by_zero;
    of = bus.OF;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] q, r, eq, er;
    logic        dz, of, edz, eof;
    logic [31:0] a, b;
    logic        s;
    int          lat;
    int          ov_cnt;

    vecs[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0};
    vecs[1] = '{32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0};
    vecs[2] = '{32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0};
    vecs[3] = '{32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b0};
    vecs[4] = '{32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0};
    vecs[6] = '{32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0};
    vecs[7] = '{32'd7, 32'd9, 1'b0, 32'd0, 32'd7, 1'b0, 1'b0};
`ifdef SEQ_DIV_SIGNED_EN
    vecs[8] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[9] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1};
`else
    vecs[8] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0};
    vecs[9] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 1'b0};
`endif

    bus.start_valid = 1'b0;
    bus.dividend    = 32'd0;
    bus.divisor     = 32'd0;
    bus.is_signed   = 1'b0;
    bus.out_ready   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_quotient", bus.quotient, 32'd0);
    chk("rst_remainder", bus.remainder, 32'd0);
    chk("rst_dz", 32'(bus.div_by_zero), 32'd0);
    chk("rst_of", 32'(bus.OF), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_start_ready", 32'(bus.start_ready), 32'd1);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, q, r, dz, of, lat);
      chk($sformatf("vec%0d_q", i), q, vecs[i].q);
      chk($sformatf("vec%0d_r", i), r, vecs[i].r);
      chk($sformatf("vec%0d_dz", i), 32'(dz), 32'(vecs[i].dz));
      chk($sformatf("vec%0d_of", i), 32'(of), 32'(vecs[i].of));
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].dz ? 32'd0 : 32'd32);
      $display("vec %0d: %h / %h s=%0d -> q=%h r=%h dz=%0d of=%0d lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].s, q, r, dz, of, lat);
    end

    // Randomized operands against the model
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom) >> $urandom_range(1, 31);
        default: b = 32'($urandom);
      endcase
      s = 1'($urandom_range(0, 1));
      model(a, b, s, eq, er, edz, eof);
      run_op(a, b, s, q, r, dz, of, lat);
      chk($sformatf("rnd%0d_q", i), q, eq);
      chk($sformatf("rnd%0d_r", i), r, er);
      chk($sformatf("rnd%0d_dz", i), 32'(dz), 32'(edz));
      chk($sformatf("rnd%0d_of", i), 32'(of), 32'(eof));
      chk($sformatf("rnd%0d_lat", i), lat, edz ? 32'd0 : 32'd32);
      $display("rnd %0d: %h / %h s=%0d -> q=%h r=%h dz=%0d of=%0d lat=%0d",
               i, a, b, s, q, r, dz, of, lat);
    end

    // Stall in DONE for 10 cycles, then back-to-back request
    @(negedge clk);
    bus.dividend    = 32'd100;
    bus.divisor     = 32'd7;
    bus.is_signed   = 1'b0;
    bus.start_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("stall_lat", lat, 32'd32);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.start_valid = 1'b1;
      bus.dividend    = 32'd9;
      bus.divisor     = 32'd3;
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_q", k), bus.quotient, 32'd14);
      chk($sformatf("stall%0d_r", k), bus.remainder, 32'd2);
      chk($sformatf("stall%0d_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("stall%0d_ready", k), 32'(bus.start_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("consume_valid", 32'(bus.out_valid), 32'd0);
    chk("consume_ready", 32'(bus.start_ready), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_accepted", 32'(bus.start_ready), 32'd0);
    bus.start_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b2b_lat", lat, 32'd32);
    chk("b2b_q", bus.quotient, 32'd3);
    chk("b2b_r", bus.remainder, 32'd0);
    $display("b2b: 9 / 3 -> q=%h r=%h lat=%0d", bus.quotient, bus.remainder, lat);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    // Reset at step 16 of 0xFFFFFFFF/3
    @(negedge clk);
    bus.dividend    = 32'hFFFF_FFFF;
    bus.divisor     = 32'd3;
    bus.is_signed   = 1'b0;
    bus.start_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    chk("abort_accepted", 32'(bus.start_ready), 32'd0);
    repeat (16) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_q", bus.quotient, 32'd0);
    chk("abort_r", bus.remainder, 32'd0);
    chk("abort_dz", 32'(bus.div_by_zero), 32'd0);
    chk("abort_of", 32'(bus.OF), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_ready", 32'(bus.start_ready), 32'd1);
    ov_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) ov_cnt++;
    end
    chk("abort_no_result", ov_cnt, 32'd0);
    run_op(32'd9, 32'd3, 1'b0, q, r, dz, of, lat);
    chk("fresh_q", q, 32'd3);
    chk("fresh_r", r, 32'd0);
    chk("fresh_lat", lat, 32'd32);
    $display("fresh: 9 / 3 -> q=%h r=%h lat=%0d", q, r, lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
